// File: rtl/soc_bus_pkg.sv
// Shared definitions for the CPU-to-slave bus fabric: FSM encoding, default widths
// and the "no default slave" convention (DEF_SLV == N_SLV).
package soc_bus_pkg;

    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 19;
    localparam int SEL_W_DEF  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } bus_state_t;

    // Passing this as DEF_SLV makes unmatched select codes return an error.
    function automatic int no_default(input int n_slv);
        return n_slv;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/soc_addr_decode.sv
// Combinational select-field decoder: lowest matching slave index wins, with an
// optional default slave for codes that match nothing.
module soc_addr_decode
    import soc_bus_pkg::*;
#(
    parameter int N_SLV   = 3,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DEF_SLV = 0,
    parameter int IDX_W   = idx_width(N_SLV)
) (
    input  logic [SEL_W-1:0]       sel_field,
    input  logic [N_SLV*SEL_W-1:0] slv_sel,
    output logic                   hit,
    output logic [IDX_W-1:0]       index
);

    // Codes are listed slave 0 first, so slave i sits at the i-th slice from the MSB.
    // Scanning downwards lets the lowest matching index overwrite any higher one.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (slv_sel[(N_SLV - 1 - i) * SEL_W +: SEL_W] == sel_field) begin
                hit   = 1'b1;
                index = IDX_W'(i);
            end
        end
        if (!hit && (DEF_SLV < N_SLV)) begin
            hit   = 1'b1;
            index = IDX_W'(DEF_SLV);
        end
    end

endmodule

// File: rtl/soc_bus_fabric.sv
// Registered single-master interconnect: decodes the CPU request, holds it on the
// selected slave until s_ready or timeout, then returns a one-cycle response pulse.
module soc_bus_fabric
    import soc_bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int N_SLV   = 3,
    parameter int SEL_HI  = 18,
    parameter int SEL_LO  = 16,
    parameter logic [N_SLV*(SEL_HI-SEL_LO+1)-1:0] SLV_SEL = {3'b000, 3'b110, 3'b111},
    parameter int DEF_SLV = 0,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_valid,
    output logic                    cpu_ready,
    input  logic                    cpu_write,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic                    cpu_rvalid,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    cpu_err,
    output logic [N_SLV-1:0]        s_valid,
    output logic                    s_write,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W-1:0]       s_wdata,
    input  logic [N_SLV-1:0]        s_ready,
    input  logic [N_SLV*DATA_W-1:0] s_rdata
);

    localparam int SEL_W = SEL_HI - SEL_LO + 1;
    localparam int IDX_W = idx_width(N_SLV);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    bus_state_t        state;
    logic [IDX_W-1:0]  sel;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic [DATA_W-1:0] rd_slice;

    soc_addr_decode #(
        .N_SLV   (N_SLV),
        .SEL_W   (SEL_W),
        .DEF_SLV (DEF_SLV),
        .IDX_W   (IDX_W)
    ) u_decode (
        .sel_field (cpu_addr[SEL_HI:SEL_LO]),
        .slv_sel   (SLV_SEL),
        .hit       (dec_hit),
        .index     (dec_idx)
    );

    assign rd_slice = s_rdata[sel * DATA_W +: DATA_W];
    // Saturating wait counter; it can never wrap back into a valid count.
    assign cnt_nxt  = (cnt == CNT_W'(TIMEOUT)) ? cnt : cnt + 1'b1;

    // s_write/s_addr/s_wdata are the request registers themselves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cpu_ready  <= 1'b1;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            cpu_err    <= 1'b0;
            s_valid    <= '0;
            s_write    <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            sel        <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_valid) begin
                        s_write   <= cpu_write;
                        s_addr    <= cpu_addr;
                        s_wdata   <= cpu_wdata;
                        cnt       <= '0;
                        cpu_ready <= 1'b0;
                        if (dec_hit) begin
                            sel     <= dec_idx;
                            s_valid <= N_SLV'(1) << dec_idx;
                            state   <= ST_REQ;
                        end else begin
                            cpu_err    <= 1'b1;
                            cpu_rdata  <= '0;
                            cpu_rvalid <= 1'b1;
                            state      <= ST_RESP;
                        end
                    end
                end
                ST_REQ: begin
                    cnt <= cnt_nxt;
                    // A ready in the final allowed cycle still wins over the timeout.
                    if (s_ready[sel]) begin
                        cpu_rdata  <= s_write ? '0 : rd_slice;
                        cpu_err    <= 1'b0;
                        cpu_rvalid <= 1'b1;
                        s_valid    <= '0;
                        state      <= ST_RESP;
                    end else if (cnt_nxt == CNT_W'(TIMEOUT)) begin
                        cpu_rdata  <= '0;
                        cpu_err    <= 1'b1;
                        cpu_rvalid <= 1'b1;
                        s_valid    <= '0;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    cpu_rvalid <= 1'b0;
                    cpu_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Randomized scoreboard bench for soc_bus_fabric: a five-slave instance with a
// duplicate code and no default slave, plus a default-parameter instance.
module tb_soc_bus_fabric;

    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 19;
    localparam int N_SLV   = 5;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                    cpu_valid = 1'b0;
    logic                    cpu_ready;
    logic                    cpu_write = 1'b0;
    logic [ADDR_W-1:0]       cpu_addr = '0;
    logic [DATA_W-1:0]       cpu_wdata = '0;
    logic                    cpu_rvalid;
    logic [DATA_W-1:0]       cpu_rdata;
    logic                    cpu_err;
    logic [N_SLV-1:0]        s_valid;
    logic                    s_write;
    logic [ADDR_W-1:0]       s_addr;
    logic [DATA_W-1:0]       s_wdata;
    logic [N_SLV-1:0]        s_ready;
    logic [N_SLV*DATA_W-1:0] s_rdata;

    soc_bus_fabric #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .N_SLV   (N_SLV),
        .SEL_HI  (18),
        .SEL_LO  (16),
        .SLV_SEL ({3'b000, 3'b110, 3'b111, 3'b110, 3'b011}),
        .DEF_SLV (N_SLV),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .cpu_valid (cpu_valid), .cpu_ready (cpu_ready), .cpu_write (cpu_write),
        .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata), .cpu_rvalid (cpu_rvalid),
        .cpu_rdata (cpu_rdata), .cpu_err (cpu_err), .s_valid (s_valid),
        .s_write (s_write), .s_addr (s_addr), .s_wdata (s_wdata),
        .s_ready (s_ready), .s_rdata (s_rdata)
    );

    // Default-parameter instance: slave 0 catches unmatched codes.
    logic                d_cpu_valid = 1'b0;
    logic                d_cpu_ready;
    logic                d_cpu_write = 1'b0;
    logic [18:0]         d_cpu_addr = '0;
    logic [18:0]         d_cpu_wdata = '0;
    logic                d_cpu_rvalid;
    logic [18:0]         d_cpu_rdata;
    logic                d_cpu_err;
    logic [2:0]          d_s_valid;
    logic                d_s_write;
    logic [18:0]         d_s_addr;
    logic [18:0]         d_s_wdata;
    logic [2:0]          d_s_ready;
    logic [3*19-1:0]     d_s_rdata = {19'h11111, 19'h22222, 19'h0ABCD};

    assign d_s_ready = d_s_valid;

    soc_bus_fabric dut_d (
        .clk (clk), .rst_n (rst_n),
        .cpu_valid (d_cpu_valid), .cpu_ready (d_cpu_ready), .cpu_write (d_cpu_write),
        .cpu_addr (d_cpu_addr), .cpu_wdata (d_cpu_wdata), .cpu_rvalid (d_cpu_rvalid),
        .cpu_rdata (d_cpu_rdata), .cpu_err (d_cpu_err), .s_valid (d_s_valid),
        .s_write (d_s_write), .s_addr (d_s_addr), .s_wdata (d_s_wdata),
        .s_ready (d_s_ready), .s_rdata (d_s_rdata)
    );

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
        logic [7:0]        lat;
        logic [7:0]        svc;
        logic [7:0]        slave;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cycle = 0;
    int   cur_delay = 0;
    logic [DATA_W-1:0] cur_rdata = '0;
    int   sv_cnt = 0;
    int   sv_seen = 0;
    exp_t mon_e;
    int   mon_a;
    int   codes[N_SLV] = '{0, 6, 7, 6, 3};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference decode: first slave in the code list whose code equals addr[18:16].
    function automatic int ref_slave(input logic [ADDR_W-1:0] a);
        for (int i = 0; i < N_SLV; i++)
            if (int'(a[18:16]) == codes[i]) return i;
        return -1;
    endfunction

    function automatic exp_t make_exp(input logic wr, input logic [ADDR_W-1:0] addr,
                                      input logic [DATA_W-1:0] wd, input int delay,
                                      input logic [DATA_W-1:0] rd);
        exp_t e;
        int s;
        e = '0;
        s = ref_slave(addr);
        e.write = wr;
        e.addr  = addr;
        e.wdata = wd;
        if (s < 0) begin
            e.slave = 8'hFF; e.err = 1'b1; e.rdata = '0; e.lat = 8'd1; e.svc = 8'd0;
        end else if (delay < TIMEOUT) begin
            e.slave = 8'(s); e.err = 1'b0; e.rdata = wr ? '0 : rd;
            e.lat = 8'(delay + 2); e.svc = 8'(delay + 1);
        end else begin
            e.slave = 8'(s); e.err = 1'b1; e.rdata = '0;
            e.lat = 8'(TIMEOUT + 1); e.svc = 8'(TIMEOUT);
        end
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // Slave models: the selected slave answers after cur_delay cycles of s_valid;
    // unselected ready bits and read-data slices carry random noise.
    initial begin
        s_ready = '0;
        s_rdata = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N_SLV; i++) s_rdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            if (rst_n && s_valid != '0) begin
                sv_cnt++;
                for (int i = 0; i < N_SLV; i++)
                    if (s_valid[i]) s_rdata[i*DATA_W +: DATA_W] = cur_rdata;
                s_ready = (N_SLV'($urandom) & ~s_valid) | ((sv_cnt == cur_delay + 1) ? s_valid : '0);
            end else begin
                sv_cnt = 0;
                s_ready = N_SLV'($urandom);
            end
        end
    end

    // Monitor: records accepts, checks slave-side requests and pops on every response.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (cpu_valid && cpu_ready) begin
                acc_q.push_back(cycle);
                sv_seen = 0;
            end
            if (s_valid != '0) begin
                sv_seen++;
                if (exp_q.size() == 0) begin
                    check("s_valid_unexpected", 64'(s_valid), 64'd0);
                end else begin
                    logic [N_SLV-1:0] oh;
                    mon_e = exp_q[0];
                    oh = '0;
                    if (mon_e.slave != 8'hFF) oh[mon_e.slave] = 1'b1;
                    check("s_valid", 64'(s_valid), 64'(oh));
                    check("s_write", 64'(s_write), 64'(mon_e.write));
                    check("s_addr", 64'(s_addr), 64'(mon_e.addr));
                    check("s_wdata", 64'(s_wdata), 64'(mon_e.wdata));
                end
            end
            if (cpu_rvalid) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    check("rvalid_unexpected", 64'(cpu_rvalid), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_a = acc_q.pop_front();
                    check("rdata", 64'(cpu_rdata), 64'(mon_e.rdata));
                    check("err", 64'(cpu_err), 64'(mon_e.err));
                    check("latency", 64'(cycle - mon_a), 64'(mon_e.lat));
                    check("s_valid_cycles", 64'(sv_seen), 64'(mon_e.svc));
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                         input int delay, input logic [DATA_W-1:0] rd, input bit hold);
        int guard;
        cur_delay = delay;
        cur_rdata = rd;
        exp_q.push_back(make_exp(wr, addr, wd, delay, rd));
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_valid = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!cpu_ready && guard < 20);
        if (!cpu_ready) check("accept_wait", 64'(cpu_ready), 64'd1);
        @(posedge clk);
        #1;
        // Holding cpu_valid through REQ/RESP must not start a second transaction.
        if (!hold) begin
            cpu_valid = 1'b0;
            cpu_write = 1'($urandom);
            cpu_addr  = ADDR_W'($urandom);
            cpu_wdata = DATA_W'($urandom);
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            check("response_wait", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            acc_q.delete();
        end
        cpu_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_req();
        int guard;
        cur_delay = TIMEOUT + 1;
        cur_rdata = 19'h12121;
        exp_q.push_back(make_exp(1'b0, 19'h01234, '0, TIMEOUT + 1, 19'h12121));
        cpu_write = 1'b0;
        cpu_addr  = 19'h01234;
        cpu_valid = 1'b1;
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (s_valid == '0 && guard < 5);
        check("pre_reset_s_valid", 64'(s_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_s_valid", 64'(s_valid), 64'd0);
        check("reset_rvalid", 64'(cpu_rvalid), 64'd0);
        check("reset_ready", 64'(cpu_ready), 64'd1);
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_ready", 64'(cpu_ready), 64'd1);
        check("post_reset_rvalid", 64'(cpu_rvalid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic default_slave_test();
        int guard;
        check("def_ready_idle", 64'(d_cpu_ready), 64'd1);
        d_cpu_write = 1'b0;
        d_cpu_addr  = 19'h50000;
        d_cpu_valid = 1'b1;
        @(posedge clk);
        #1;
        d_cpu_valid = 1'b0;
        guard = 0;
        while (!d_cpu_rvalid && guard < 10) begin
            @(negedge clk);
            if (d_s_valid != '0) check("def_s_valid", 64'(d_s_valid), 64'd1);
            guard++;
        end
        check("def_rvalid", 64'(d_cpu_rvalid), 64'd1);
        check("def_rdata", 64'(d_cpu_rdata), 64'h0ABCD);
        check("def_err", 64'(d_cpu_err), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", 64'(cpu_ready), 64'd1);
        check("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
        check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        check("rst_cpu_err", 64'(cpu_err), 64'd0);
        check("rst_s_valid", 64'(s_valid), 64'd0);
        check("rst_s_write", 64'(s_write), 64'd0);
        check("rst_s_addr", 64'(s_addr), 64'd0);
        check("rst_s_wdata", 64'(s_wdata), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        default_slave_test();

        issue(1'b0, 19'h01234, 19'h0,     1,           19'h0ABCD, 1'b0);
        issue(1'b1, 19'h70010, 19'h00055, 0,           19'h12345, 1'b0);
        issue(1'b0, 19'h50000, 19'h0,     0,           19'h00001, 1'b0);
        issue(1'b0, 19'h60000, 19'h0,     TIMEOUT + 1, 19'h00002, 1'b0);
        issue(1'b0, 19'h60000, 19'h0,     TIMEOUT - 1, 19'h33333, 1'b0);
        issue(1'b0, 19'h3ABCD, 19'h0,     2,           19'h44444, 1'b0);
        issue(1'b1, 19'h6FFFF, 19'h00007, TIMEOUT,     19'h55555, 1'b1);
        issue(1'b0, 19'h0FFFF, 19'h0,     0,           19'h66666, 1'b1);

        reset_mid_req();
        issue(1'b0, 19'h01234, 19'h0, 0, 19'h0ABCD, 1'b0);

        for (int n = 0; n < 40; n++) begin
            issue(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
                  int'($urandom_range(0, TIMEOUT + 1)), DATA_W'($urandom),
                  ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
